shape_sequencer: RTL

SHAPE_SEQUENCER -- requirements
Module: shape_sequencer

---
 rtl/shape_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/shape_sequencer.sv
// Queues DRAW commands and emits triangle or square vertices as a point stream.
// Reserved opcodes pulse cmd_err; NOPs are dropped.
module shape_sequencer #(
    parameter int width   = 4,
    parameter int height  = 3,
    parameter int op_size = 2,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [op_size-1:0] cmd_op,
    input  logic               cmd_shape,
    input  logic [width-1:0]   cmd_x1,
    input  logic [width-1:0]   cmd_x2,
    input  logic [width-1:0]   cmd_x3,
    input  logic [height-1:0]  cmd_y1,
    input  logic [height-1:0]  cmd_y2,
    input  logic [height-1:0]  cmd_y3,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [width-1:0]   pt_x,
    output logic [height-1:0]  pt_y,
    output logic [1:0]         pt_idx,
    output logic               pt_last,
    output logic               busy,
    output logic               cmd_err,
    output logic [7:0]         shape_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [op_size-1:0] op;
        logic               shape;
        logic [width-1:0]   x1;
        logic [width-1:0]   x2;
        logic [width-1:0]   x3;
        logic [height-1:0]  y1;
        logic [height-1:0]  y2;
        logic [height-1:0]  y3;
    } cmd_t;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    cmd_t            mem_q [DEPTH];
    cmd_t            cmd_in;
    cmd_t            cur_q;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      count_q, count_d;
    logic            err_q;
    logic            accept;
    logic            push;
    logic            pop;
    logic            last;

    assign cmd_in = '{
        op:    cmd_op,
        shape: cmd_shape,
        x1:    cmd_x1,
        x2:    cmd_x2,
        x3:    cmd_x3,
        y1:    cmd_y1,
        y2:    cmd_y2,
        y3:    cmd_y3
    };

    assign cmd_ready = (cnt_q != CW'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && (cmd_op == op_size'(1));

    // Pointers wrap explicitly so a non-power-of-two depth still behaves.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign last = cur_q.shape ? (idx_q == 2'd3) : (idx_q == 2'd2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = EMIT;
                    idx_d   = 2'd0;
                end
            end
            EMIT: begin
                if (pt_ready) begin
                    if (last) begin
                        count_d = count_q + 8'd1;
                        idx_d   = 2'd0;
                        if (cnt_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            count_q <= 8'd0;
            err_q   <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            err_q   <= accept && (cmd_op > op_size'(1));
            if (pop) begin
                cur_q <= mem_q[rptr_q];
            end
        end
    end

    // Square's fourth vertex reuses x2 with y3.
    always_comb begin
        pt_x = cur_q.x1;
        pt_y = cur_q.y1;
        unique case (idx_q)
            2'd0: begin
                pt_x = cur_q.x1;
                pt_y = cur_q.y1;
            end
            2'd1: begin
                pt_x = cur_q.x2;
                pt_y = cur_q.y2;
            end
            2'd2: begin
                pt_x = cur_q.x3;
                pt_y = cur_q.y3;
            end
            default: begin
                pt_x = cur_q.x2;
                pt_y = cur_q.y3;
            end
        endcase
    end

    assign pt_valid    = (state_q == EMIT);
    assign pt_idx      = idx_q;
    assign pt_last     = last;
    assign busy        = (cnt_q != '0) || (state_q == EMIT);
    assign cmd_err     = err_q;
    assign shape_count = count_q;

endmodule
